// File: rtl/iqueue_dispatch.sv
// iqueue_dispatch: issue stage between the instruction queue and the ALU.
// Holds one 16-bit word until its registers are hazard-free, then issues it.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/valid/ready   instruction queue handshake
//                         fields: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2
//   wb_valid, wb_reg      ALU writeback, clears the register's busy bit
//   out_valid/ready       ALU handshake
//   out_opcode/rd/rs1/rs2 registered fields of the issued instruction
//   busy                  per-register scoreboard (debug)
//   stall_cycles          hazard-stall counter
//
// Build option: IDISPATCH_PERF_EN enables the saturating stall counter;
// without it stall_cycles is tied to zero.
module iqueue_dispatch #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_valid,
    input  logic [3:0]            wb_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_opcode,
    output logic [3:0]            out_rd,
    output logic [3:0]            out_rs1,
    output logic [3:0]            out_rs2,
    output logic [NUM_REGS-1:0]   busy,
    output logic [15:0]           stall_cycles
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_STALL = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] hold_q;
    logic [3:0]            h_op;
    logic [3:0]            h_rd;
    logic [3:0]            h_rs1;
    logic [3:0]            h_rs2;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] set_mask;

    logic [3:0] op_q;
    logic [3:0] rd_q;
    logic [3:0] rs1_q;
    logic [3:0] rs2_q;

    logic hazard;
    logic hold_load;
    logic issue;

    assign h_op  = hold_q[15:12];
    assign h_rd  = hold_q[11:8];
    assign h_rs1 = hold_q[7:4];
    assign h_rs2 = hold_q[3:0];

    // Writeback bypass: a register being written back this cycle is
    // already treated as free by the hazard check.
    always_comb begin
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_reg] = 1'b1;
        end
    end

    assign busy_eff = busy_q & ~wb_mask;

    always_comb begin
        hazard = 1'b0;
        if (h_op != 4'h0) begin
            hazard = busy_eff[h_rs1]
                   | busy_eff[h_rs2]
                   | busy_eff[h_rd];
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        issue     = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                // Gated so no handshake appears while reset is held.
                in_ready = reset_n;
                if (in_valid) begin
                    hold_load = 1'b1;
                    state_d   = S_STALL;
                end
            end
            S_STALL: begin
                if (!hazard) begin
                    issue   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        hold_load = 1'b1;
                        state_d   = S_STALL;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Issue set is applied after the writeback clear so the set wins.
    always_comb begin
        set_mask = '0;
        if (issue && (h_op != 4'h0)) begin
            set_mask[h_rd] = 1'b1;
        end
    end

    assign busy_d = (busy_q & ~wb_mask) | set_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            hold_q  <= '0;
            busy_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (hold_load) begin
                hold_q <= in_data;
            end
            if (issue) begin
                op_q  <= h_op;
                rd_q  <= h_rd;
                rs1_q <= h_rs1;
                rs2_q <= h_rs2;
            end
        end
    end

    assign out_valid  = (state_q == S_ISSUE);
    assign out_opcode = op_q;
    assign out_rd     = rd_q;
    assign out_rs1    = rs1_q;
    assign out_rs2    = rs2_q;
    assign busy       = busy_q;

`ifdef IDISPATCH_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if ((state_q == S_STALL) && hazard
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_iqueue_dispatch.sv
// tb_iqueue_dispatch: vector table plus hand sequences for iqueue_dispatch.
// Issued fields are checked against a queue of expected words.
module tb_iqueue_dispatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [15:0] busy;
    logic [15:0] stall_cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] instr;
        logic        wb_en;
        logic [3:0]  wb_r;
        logic [15:0] exp_busy;
    } vec_t;

    vec_t vecs[8];

`ifdef IDISPATCH_PERF_EN
    localparam logic [15:0] EXP_STALL10 = 16'd10;
`else
    localparam logic [15:0] EXP_STALL10 = 16'd0;
`endif

    iqueue_dispatch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every completed ALU handshake pops one expected word.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL issue_unexpected: got %h expected none",
                         {out_opcode, out_rd, out_rs1, out_rs2});
            end else begin
                check("issue_fields",
                      {16'h0, out_opcode, out_rd, out_rs1, out_rs2},
                      {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'h0, 32'h1);
        end else begin
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_wb(input logic [3:0] r);
        @(posedge clk);
        #1;
        wb_valid = 1'b1;
        wb_reg   = r;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h1123, 1'b1, 4'h1, 16'h0002};
        vecs[1] = '{16'h3567, 1'b1, 4'h5, 16'h0020};
        vecs[2] = '{16'hF9AB, 1'b0, 4'h0, 16'h0200};
        vecs[3] = '{16'h0999, 1'b0, 4'h0, 16'h0200};
        vecs[4] = '{16'h7C01, 1'b1, 4'h9, 16'h1200};
        vecs[5] = '{16'h2E3D, 1'b1, 4'hC, 16'h5000};
        vecs[6] = '{16'h8000, 1'b1, 4'h0, 16'h4001};
        vecs[7] = '{16'h4F12, 1'b1, 4'hE, 16'hC000};

        // Reset values, no clock edge yet.
        #3;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {16'h0, busy}, 32'h0);
        check("rst_stall", {16'h0, stall_cycles}, 32'h0);
        check("rst_fields",
              {16'h0, out_opcode, out_rd, out_rs1, out_rs2}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'h0, in_ready}, 32'h1);

        // Table: independent instructions, ALU always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].instr);
            @(negedge clk);
            check("lat_check_cycle", {31'h0, out_valid}, 32'h0);
            @(negedge clk);
            check("lat_issue", {31'h0, out_valid}, 32'h1);
            check("vec_busy", {16'h0, busy}, {16'h0, vecs[i].exp_busy});
            if (vecs[i].wb_en) begin
                pulse_wb(vecs[i].wb_r);
            end
        end
        @(negedge clk);
        check("vec_no_stall", {16'h0, stall_cycles}, 32'h0);

        // RAW stall and backpressure.
        out_ready = 1'b0;
        do_reset();
        send(16'h1123);
        @(negedge clk);
        check("b_check_cycle", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        check("b_issue", {31'h0, out_valid}, 32'h1);
        check("b_busy", {16'h0, busy}, 32'h0002);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_fields",
                  {16'h0, out_opcode, out_rd, out_rs1, out_rs2},
                  32'h1123);
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        in_data   = 16'h2415;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(16'h2415);
        @(negedge clk);
        check("bp_release_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_stall_valid", {31'h0, out_valid}, 32'h0);
            check("raw_stall_busy", {16'h0, busy}, 32'h0002);
        end
        pulse_wb(4'h1);
        @(negedge clk);
        check("raw_bypass_issue", {31'h0, out_valid}, 32'h1);
        check("raw_busy", {16'h0, busy}, 32'h0010);

        // Writeback and issue on the same register and edge.
        send(16'h3300);
        @(negedge clk);
        @(negedge clk);
        check("sc_first_issue", {31'h0, out_valid}, 32'h1);
        check("sc_busy_pre", {16'h0, busy}, 32'h0018);
        send(16'h6301);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("sc_waw_stall", {31'h0, out_valid}, 32'h0);
        end
        pulse_wb(4'h3);
        @(negedge clk);
        check("sc_issue", {31'h0, out_valid}, 32'h1);
        check("sc_busy_kept", {16'h0, busy}, 32'h0018);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);

        // Stall counter, then reset in the middle of a stall.
        do_reset();
        send(16'h1123);
        @(negedge clk);
        @(negedge clk);
        check("d_issue", {31'h0, out_valid}, 32'h1);
        send(16'h2415);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("d_stalled", {31'h0, out_valid}, 32'h0);
        check("d_stall_cycles", {16'h0, stall_cycles},
              {16'h0, EXP_STALL10});
        #1;
        reset_n = 1'b0;
        #1;
        check("d_rst_valid", {31'h0, out_valid}, 32'h0);
        check("d_rst_busy", {16'h0, busy}, 32'h0);
        check("d_rst_stall", {16'h0, stall_cycles}, 32'h0);
        check("d_rst_in_ready", {31'h0, in_ready}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("d_post_rst_ready", {31'h0, in_ready}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
